// File: rtl/core_id_ibuf.sv
// Instruction buffer between fetch and ID decode: DEPTH-entry FIFO of {pc, inst}.
// Optional same-cycle bypass through an empty buffer: define CORE_ID_IBUF_BYPASS_EN.
`ifndef CORE_PC_WIDTH
`define CORE_PC_WIDTH 32
`endif
`ifndef CORE_INST_WIDTH
`define CORE_INST_WIDTH 32
`endif

module core_id_ibuf #(
  parameter int PC_W   = `CORE_PC_WIDTH,
  parameter int INST_W = `CORE_INST_WIDTH,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [INST_W-1:0] i_inst,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [PC_W-1:0]   o_pc,
  output logic [INST_W-1:0] o_inst,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_empty,
  output logic              o_full
);

  localparam int PTR_W = $clog2(DEPTH);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // valid_in may not be withdrawn and i_pc/i_inst must stay stable while ready_in=0;
  // ready_in depends only on occupancy, never on ready_out.

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              wr_en;
  logic              rd_en;
  logic              byp;

`ifdef CORE_ID_IBUF_BYPASS_EN
  assign byp = o_empty & valid_in & ~i_flush;
`else
  assign byp = 1'b0;
`endif

  assign o_count   = count;
  assign o_empty   = (count == '0);
  assign o_full    = (count == CNT_W'(DEPTH));
  assign ready_in  = ~o_full;
  assign valid_out = ~o_empty | byp;
  assign o_pc      = byp ? i_pc   : pc_mem[rd_ptr];
  assign o_inst    = byp ? i_inst : inst_mem[rd_ptr];

  assign push = valid_in & ready_in;
  assign pop  = valid_out & ready_out;
  // A bypassed entry taken by decode in the same cycle never touches storage.
  assign wr_en = push & ~(byp & ready_out);
  assign rd_en = pop & ~byp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        pc_mem[wr_ptr]   <= i_pc;
        inst_mem[wr_ptr] <= i_inst;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (wr_en & ~rd_en) begin
        count <= count + CNT_W'(1);
      end else if (rd_en & ~wr_en) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_core_id_ibuf.sv
// Randomized + directed bench for core_id_ibuf (DEPTH=4) against a queue-based model.
module tb_core_id_ibuf;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH+1);

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              i_flush   = 1'b0;
  logic              valid_in  = 1'b0;
  logic              ready_in;
  logic [PC_W-1:0]   i_pc      = '0;
  logic [INST_W-1:0] i_inst    = '0;
  logic              valid_out;
  logic              ready_out = 1'b0;
  logic [PC_W-1:0]   o_pc;
  logic [INST_W-1:0] o_inst;
  logic [CNT_W-1:0]  o_count;
  logic              o_empty;
  logic              o_full;

  core_id_ibuf #(
    .PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .valid_in(valid_in), .ready_in(ready_in), .i_pc(i_pc), .i_inst(i_inst),
    .valid_out(valid_out), .ready_out(ready_out), .o_pc(o_pc), .o_inst(o_inst),
    .o_count(o_count), .o_empty(o_empty), .o_full(o_full)
  );

  // scoreboard: entries the buffer should hold, head first
  logic [PC_W+INST_W-1:0] exp_q[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
  task automatic rst_pulse();
    valid_in  = 1'b0;
    ready_out = 1'b0;
    i_flush   = 1'b0;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("rst_valid_out", valid_out, 0);
    check("rst_ready_in",  ready_in,  1);
    check("rst_count",     o_count,   0);
    check("rst_empty",     o_empty,   1);
    check("rst_full",      o_full,    0);
    check("rst_pc",        o_pc,      0);
    check("rst_inst",      o_inst,    0);
    #1;
    rst = 1'b0;
  endtask

  // Drive one cycle, compare combinational outputs, then advance the model past the edge.
  task automatic cycle(input logic v, input logic [PC_W-1:0] pc, input logic [INST_W-1:0] inst,
                       input logic rdy, input logic fl);
    logic ev, er, byp, acc, con;
    logic [PC_W+INST_W-1:0] head;
    valid_in  = v;
    i_pc      = pc;
    i_inst    = inst;
    ready_out = rdy;
    i_flush   = fl;
    #1;
    er  = exp_q.size() < DEPTH;
    byp = 1'b0;
`ifdef CORE_ID_IBUF_BYPASS_EN
    byp = (exp_q.size() == 0) && v && !fl;
`endif
    ev = (exp_q.size() != 0) || byp;
    check("valid_out", valid_out, ev);
    check("ready_in",  ready_in,  er);
    check("count",     o_count,   exp_q.size());
    check("empty",     o_empty,   exp_q.size() == 0);
    check("full",      o_full,    exp_q.size() == DEPTH);
    if (ev) begin
      head = (exp_q.size() != 0) ? exp_q[0] : {pc, inst};
      check("head_pc",   o_pc,   head[PC_W+INST_W-1:INST_W]);
      check("head_inst", o_inst, head[INST_W-1:0]);
    end
    acc = v && er;
    con = ev && rdy;
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (acc) exp_q.push_back({pc, inst});
      if (con) void'(exp_q.pop_front());
    end
  endtask

  function automatic logic [INST_W-1:0] mk_inst(input logic [PC_W-1:0] pc);
    return (pc * 3) ^ 32'h1357_0000;
  endfunction

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, rdy, 1'b0);
  endtask

  initial begin
    logic [PC_W-1:0] pc;
    @(posedge clk);
    #1;
    rst_pulse();
    idle(2, 1'b0);

    // fill to full, then a 5th push that must be refused
    for (int i = 0; i < 4; i++) begin
      pc = 32'h100 + 32'(4 * i);
      cycle(1'b1, pc, mk_inst(pc), 1'b0, 1'b0);
    end
    cycle(1'b1, 32'h110, mk_inst(32'h110), 1'b0, 1'b0);

    // drain, then push 6 more with decode taking them so the pointers wrap
    idle(5, 1'b1);
    for (int i = 0; i < 6; i++) begin
      pc = 32'h180 + 32'(4 * i);
      cycle(1'b1, pc, mk_inst(pc), i[0], 1'b0);
    end
    idle(6, 1'b1);

    // steady-state push+pop at count 2
    cycle(1'b1, 32'h1F0, mk_inst(32'h1F0), 1'b0, 1'b0);
    cycle(1'b1, 32'h1F4, mk_inst(32'h1F4), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      pc = 32'h200 + 32'(4 * i);
      cycle(1'b1, pc, mk_inst(pc), 1'b1, 1'b0);
    end
    idle(3, 1'b1);

    // flush at count 3 with a simultaneous push that must be dropped
    for (int i = 0; i < 3; i++) begin
      pc = 32'h2F0 + 32'(4 * i);
      cycle(1'b1, pc, mk_inst(pc), 1'b0, 1'b0);
    end
    cycle(1'b1, 32'h300, mk_inst(32'h300), 1'b0, 1'b1);
    idle(2, 1'b1);

    // empty-buffer push: taken immediately, then held with decode stalled
    cycle(1'b1, 32'h400, mk_inst(32'h400), 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    cycle(1'b1, 32'h400, mk_inst(32'h400), 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(2, 1'b1);

    // reset in the middle of traffic
    for (int i = 0; i < 3; i++) begin
      pc = 32'h500 + 32'(4 * i);
      cycle(1'b1, pc, mk_inst(pc), 1'b0, 1'b0);
    end
    rst_pulse();
    idle(2, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      pc = $urandom;
      cycle(1'($urandom_range(0, 3) != 0), pc, $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end
    idle(DEPTH + 2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/core_id_ibuf.md
Name: core_id_ibuf

Overview:
- Parametrised instruction buffer between the fetch stage and the ID decoder.
- Replaces the single pc/inst register stage with a DEPTH-entry queue carrying {pc, inst} pairs.
- Provides a valid/ready handshake on both sides where valid_out reflects actual occupancy, plus a front-end flush for redirects.
- Outputs feed core_id_decode directly.

Parameters:
- PC_W, `CORE_PC_WIDTH, pc field width.
- INST_W, `CORE_INST_WIDTH, instruction field width.
- DEPTH, 2, number of entries; power of two, DEPTH >= 2.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- i_flush  in  1  synchronous flush (branch/exception redirect).
- valid_in  in  1  fetch presents a valid pc/inst.
- ready_in  out  1  buffer can accept this cycle.
- i_pc  in  PC_W  fetched pc.
- i_inst  in  INST_W  fetched instruction.
- valid_out  out  1  head entry valid toward decode.
- ready_out  in  1  decode consumes head this cycle.
- o_pc  out  PC_W  head pc.
- o_inst  out  INST_W  head instruction.
- o_count  out  CNT_W  current occupancy, 0..DEPTH.
- o_empty  out  1  occupancy == 0.
- o_full  out  1  occupancy == DEPTH.

Behaviour:
- Reset (rst high, asynchronous):
  - wr_ptr, rd_ptr and count are 0.
  - All storage entries are 0.
  - Outputs at reset: valid_out=0, ready_in=1, o_pc=0, o_inst=0, o_count=0, o_empty=1, o_full=0.
  - Deasserting rst mid-operation leaves the buffer empty; any in-flight entries are discarded.
- Push = valid_in & ready_in. Pop = valid_out & ready_out.
- ready_in = ~o_full.
  - ready_in does not depend on ready_out (no combinational path).
  - When full, a same-cycle pop does not enable a push.
- valid_out = ~o_empty (non-bypass build).
- o_pc/o_inst = storage[rd_ptr], combinational read of the head entry.
  - Value is don't-care while valid_out=0, but must not be X after reset.
- On push: storage[wr_ptr] <= {i_pc, i_inst}; wr_ptr increments.
- On pop: rd_ptr increments.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop (legal whenever 0 < count < DEPTH).
- Latency, non-bypass: data pushed in cycle N is visible with valid_out=1 in cycle N+1 at the earliest.
- Throughput: one entry per cycle sustained when ready_out=1 and DEPTH >= 2.
- Flush (i_flush=1 at a clock edge):
  - wr_ptr, rd_ptr and count go to 0.
  - A same-cycle push is dropped; a same-cycle pop is irrelevant.
  - Flush has priority over push and pop.
  - In the cycle after the flush: valid_out=0 and ready_in=1.
  - Storage contents are not cleared.
- Ordering: strict FIFO; no reordering, no duplication, no loss except on flush.
- Empty with pop attempt: impossible, since valid_out=0; no state change.
- Full with push attempt: impossible, since ready_in=0; fetch must hold i_pc/i_inst stable.
- o_count never exceeds DEPTH. o_empty and o_full are never both 1.

Optional Feature:
- Macro: CORE_ID_IBUF_BYPASS_EN.
- Defined (bypass enabled):
  - When count==0 and valid_in=1 and i_flush=0: valid_out=1 and o_pc/o_inst=i_pc/i_inst combinationally in the same cycle.
  - If ready_out=1 in that cycle, the entry is consumed without being written: pointers and count unchanged.
  - If ready_out=0, the entry is written normally and stays at the head.
  - valid_out = ~o_empty | (valid_in & ~i_flush).
  - Zero-cycle latency through an empty buffer.
- Not defined: no combinational path from i_pc/i_inst/valid_in to the outputs; minimum latency is 1 cycle, as above.

Test Plan:
- Reset, then idle: rst pulse with no clock edge -> valid_out=0, ready_in=1, o_count=0, o_empty=1, o_pc=0, o_inst=0 immediately.
- Fill to full, DEPTH=4, ready_out=0:
  - Push pc 0x100/0x104/0x108/0x10C -> o_count=4, o_full=1, ready_in=0.
  - A 5th valid_in is not accepted.
  - o_pc=0x100.
- Drain with wrap:
  - From full, ready_out=1 for 4 cycles -> o_pc sequence 0x100, 0x104, 0x108, 0x10C, then valid_out=0.
  - Push 6 more entries -> pointers wrap and FIFO order is preserved.
- Simultaneous push and pop:
  - count=2, valid_in=1 (pc 0x200), ready_out=1 for 10 cycles -> count stays 2.
  - Each inst appears on the outputs exactly once, in order.
- Flush with push:
  - count=3, i_flush=1 together with valid_in=1 (pc 0x300) -> next cycle o_count=0, valid_out=0.
  - 0x300 never appears at the outputs.
- Bypass (macro defined):
  - Empty, valid_in=1 with pc 0x400 and ready_out=1 -> same cycle valid_out=1, o_pc=0x400; o_count stays 0.
  - Repeat with ready_out=0 -> o_count=1 next cycle, o_pc=0x400.
  - Without the macro, the first valid_out appears one cycle after the push.
